// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Transmit buffer between the CPU's memory-mapped UART data register and
//   simpleuart's reg_dat_we / reg_dat_wait handshake. Each rising edge of the
//   CPU write strobe queues one byte in a circular FIFO. A three-state drain
//   FSM hands the bytes to simpleuart one at a time.
//
// Ports
//   clk        in   1             system clock, rising edge
//   resetn     in   1             asynchronous active-low reset
//   cpu_we     in   1             CPU write strobe (level; one byte per rise)
//   cpu_wdata  in   8             byte to queue
//   ovf_clr    in   1             pulse, clears the sticky overflow flag
//   uart_we    out  1             to simpleuart reg_dat_we
//   uart_data  out  8             to simpleuart reg_dat_di, held while uart_we=1
//   uart_wait  in   1             from simpleuart reg_dat_wait
//   count      out  DEPTH_LOG2+1  bytes held, including the presented byte
//   status     out  8             registered {ovf, 4'b0, busy, full, empty}

module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_we,
    input  logic [7:0]            cpu_wdata,
    input  logic                  ovf_clr,
    output logic                  uart_we,
    output logic [7:0]            uart_data,
    input  logic                  uart_wait,
    output logic [DEPTH_LOG2:0]   count,
    output logic [7:0]            status
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } state_t;

    state_t state, state_next;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic                  cpu_we_q;
    logic                  push;
    logic                  do_write;
    logic                  empty;
    logic                  full;
    logic                  busy;
    logic                  ovf;
    logic                  pop;
    logic                  load;

    // A strobe held for several cycles must queue only one byte, so only the
    // rising edge of cpu_we counts as a push.
    assign push     = cpu_we & ~cpu_we_q;

    // Pointers carry one extra wrap bit so that full and empty differ.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                      (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
    assign do_write = push & ~full;
    assign count    = wr_ptr - rd_ptr;
    assign busy     = (state != IDLE) || !empty;

    // Storage has no reset; its contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= cpu_wdata;
        end
    end

    // Drain FSM next-state logic. The byte stays in the FIFO (rd_ptr does
    // not move) until simpleuart accepts it. This keeps count covering the
    // presented byte. GAP holds uart_we low for one cycle after an accept,
    // because simpleuart's wait is derived from its bit counter and would
    // otherwise see a second write.
    always_comb begin
        state_next = state;
        uart_we    = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    load       = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                uart_we = 1'b1;
                if (!uart_wait) begin
                    pop        = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, pointers, edge detector, overflow flag, output data and the
    // registered status byte. Overflow checks full before this cycle's pop,
    // so a push on a full FIFO is dropped even if a byte leaves on the same
    // edge. A set of ovf takes priority over ovf_clr.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cpu_we_q  <= 1'b0;
            ovf       <= 1'b0;
            uart_data <= 8'h00;
            status    <= 8'h01;
        end else begin
            state    <= state_next;
            cpu_we_q <= cpu_we;
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && full) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (load) begin
                uart_data <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
            status <= {ovf, 4'b0000, busy, full, empty};
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed self-checking bench for uart_tx_fifo with DEPTH_LOG2=4.
//   Inputs change 1 ns after the rising edge. Outputs are checked at that
//   same point. A negedge monitor records every byte that simpleuart would
//   accept.

module tb_uart_tx_fifo;

    logic       clk;
    logic       resetn;
    logic       cpu_we;
    logic [7:0] cpu_wdata;
    logic       ovf_clr;
    logic       uart_we;
    logic [7:0] uart_data;
    logic       uart_wait;
    logic [4:0] count;
    logic [7:0] status;

    int         n_asserts = 0;
    int         n_fail    = 0;
    logic [7:0] accepted[$];
    int         gap_err   = 0;
    logic       prev_acc  = 1'b0;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .ovf_clr   (ovf_clr),
        .uart_we   (uart_we),
        .uart_data (uart_data),
        .uart_wait (uart_wait),
        .count     (count),
        .status    (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept monitor. It sees mid-cycle values, so a byte counts as accepted
    // when uart_we=1 and uart_wait=0 in the same cycle. It also flags any
    // uart_we that directly follows an accept.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_acc = 1'b0;
        end else begin
            if (uart_we && prev_acc) gap_err++;
            prev_acc = uart_we && !uart_wait;
            if (prev_acc) accepted.push_back(uart_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising strobe for a single cycle, then one low cycle.
    task automatic applyStimulus(input logic [7:0] d);
        cpu_wdata = d;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
        tick();
    endtask

    task automatic waitAccepts(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (accepted.size() >= n) break;
            tick();
        end
        checkOutput("accept_count", accepted.size(), n);
    endtask

    task automatic checkAccepted(input string tag, input int idx, input logic [7:0] exp);
        logic [7:0] got;
        got = (idx < accepted.size()) ? accepted[idx] : 8'hxx;
        checkOutput(tag, {24'h0, got}, {24'h0, exp});
    endtask

    initial begin
        resetn    = 1'b0;
        cpu_we    = 1'b0;
        cpu_wdata = 8'h00;
        ovf_clr   = 1'b0;
        uart_wait = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_uart_we", uart_we, 1'b0);
        checkOutput("rst_uart_data", uart_data, 8'h00);
        checkOutput("rst_count", count, 5'd0);
        checkOutput("rst_status", status, 8'h01);
        resetn = 1'b1;
        tick();

        // Test 1: single byte, uart_we at t+2 for one cycle.
        $display("[TB] single push latency");
        accepted.delete();
        cpu_wdata = 8'h41;
        cpu_we    = 1'b1;
        tick();
        cpu_we    = 1'b0;
        checkOutput("t1_count_t1", count, 5'd1);
        checkOutput("t1_we_t1", uart_we, 1'b0);
        checkOutput("t1_status_t1", status, 8'h01);
        tick();
        checkOutput("t1_we_t2", uart_we, 1'b1);
        checkOutput("t1_data_t2", uart_data, 8'h41);
        checkOutput("t1_status_t2", status, 8'h04);
        tick();
        checkOutput("t1_we_t3", uart_we, 1'b0);
        checkOutput("t1_count_t3", count, 5'd0);
        tick();
        checkOutput("t1_status_t4", status, 8'h05);
        tick();
        checkOutput("t1_status_t5", status, 8'h01);
        checkOutput("t1_accepts", accepted.size(), 1);
        checkAccepted("t1_byte", 0, 8'h41);

        // Test 2: strobe held five cycles queues one byte.
        $display("[TB] held strobe");
        accepted.delete();
        cpu_wdata = 8'h55;
        cpu_we    = 1'b1;
        tick();
        checkOutput("t2_count", count, 5'd1);
        repeat (4) tick();
        cpu_we = 1'b0;
        repeat (4) tick();
        checkOutput("t2_accepts", accepted.size(), 1);
        checkAccepted("t2_byte", 0, 8'h55);
        checkOutput("t2_count_end", count, 5'd0);

        // Test 3 + 5: fill with wait held, overflow, clear priority, drain.
        $display("[TB] fill, overflow, drain");
        accepted.delete();
        uart_wait = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(8'(i));
        checkOutput("t3_count_full", count, 5'd16);
        checkOutput("t3_we_held", uart_we, 1'b1);
        checkOutput("t3_data_held", uart_data, 8'h00);
        tick();
        checkOutput("t3_status_full", status, 8'h06);
        applyStimulus(8'h10);
        checkOutput("t3_count_ovf", count, 5'd16);
        checkOutput("t3_status_ovf", status, 8'h86);
        cpu_wdata = 8'h11;
        cpu_we    = 1'b1;
        ovf_clr   = 1'b1;
        tick();
        cpu_we    = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        checkOutput("t5_set_wins", status, 8'h86);
        checkOutput("t5_count", count, 5'd16);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick();
        checkOutput("t5_clr_alone", status, 8'h06);
        uart_wait = 1'b0;
        waitAccepts(16, 100);
        for (int i = 0; i < 16; i++) checkAccepted("t3_order", i, 8'(i));
        checkOutput("t3_gap", gap_err, 0);
        repeat (4) tick();
        checkOutput("t3_count_end", count, 5'd0);
        checkOutput("t3_status_end", status, 8'h01);

        // Test 4: 40 bytes through a 16-deep FIFO, pointers wrap.
        $display("[TB] streaming across wrap");
        accepted.delete();
        for (int i = 0; i < 40; i++) begin
            cpu_wdata = 8'(8'h80 + i);
            cpu_we    = 1'b1;
            tick();
            cpu_we    = 1'b0;
            tick();
            tick();
        end
        waitAccepts(40, 60);
        for (int i = 0; i < 40; i++) checkAccepted("t4_order", i, 8'(8'h80 + i));
        repeat (4) tick();
        checkOutput("t4_status_end", status, 8'h01);
        checkOutput("t4_gap", gap_err, 0);

        // Test 6: reset while a byte is presented and held off.
        $display("[TB] reset mid-transfer");
        accepted.delete();
        uart_wait = 1'b1;
        applyStimulus(8'h33);
        checkOutput("t6_we_before", uart_we, 1'b1);
        checkOutput("t6_data_before", uart_data, 8'h33);
        tick();
        resetn = 1'b0;
        #1;
        checkOutput("t6_we_async", uart_we, 1'b0);
        checkOutput("t6_count_async", count, 5'd0);
        checkOutput("t6_status_async", status, 8'h01);
        #2;
        resetn    = 1'b1;
        uart_wait = 1'b0;
        tick();
        applyStimulus(8'h7E);
        waitAccepts(1, 20);
        checkAccepted("t6_byte", 0, 8'h7E);
        repeat (4) tick();
        checkOutput("t6_single", accepted.size(), 1);
        checkOutput("t6_status_end", status, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
